// File: rtl/des_block_packer.sv
// rtl/des_block_packer.sv - pairs 32-bit PipeIn words into 64-bit DES blocks and queues them through a BRAM FIFO
module des_block_packer #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  okClk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_write,
    input  logic [31:0]           in_data,
    output logic                  blk_valid,
    input  logic                  blk_ready,
    output logic [63:0]           blk_data,
    output logic [DEPTH_LOG2:0]   blk_count,
    output logic                  word_pending,
    output logic                  overflow
);

    localparam int                    DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic {
        ST_EVEN = 1'b0,
        ST_ODD  = 1'b1
    } state_t;

    // Reset and the host flush trigger have identical effect.
    logic clear;
    assign clear = reset | flush;

    // ---------------- pairing FSM ----------------
    state_t      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic        push_req;
    logic [63:0] push_data;

    // Next-state: first word of a pair is held, second word completes the block.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        push_req  = 1'b0;
        push_data = {in_data, hold_q};
        if (in_write) begin
            case (state_q)
                ST_EVEN: begin
                    hold_d  = in_data;
                    state_d = ST_ODD;
                end
                ST_ODD: begin
                    push_req = 1'b1;
                    state_d  = ST_EVEN;
                end
                default: state_d = ST_EVEN;
            endcase
        end
    end

    // Pairing state register; a word arriving with clear is discarded.
    always_ff @(posedge okClk) begin
        if (clear) begin
            state_q <= ST_EVEN;
            hold_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // ---------------- block FIFO ----------------
    // Storage path: mem -> rd_data_q (BRAM read register) -> blk_data_q (output register).
    // count_q covers every block in all three places.
    logic [63:0]           mem [DEPTH];
    logic [63:0]           rd_data_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  out_valid_q, out_valid_d;
    logic [63:0]           blk_data_q, blk_data_d;
    logic                  overflow_q, overflow_d;

    logic                  pop;
    logic                  push_ok;
    logic                  out_load;
    logic                  s1_free;
    logic [DEPTH_LOG2:0]   in_pipe;
    logic                  rd_en;

    // Handshake, push admission and prefetch control.
    always_comb begin
        pop      = out_valid_q & blk_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok  = push_req & ~clear & ((count_q != FULL_CNT) | pop);
        out_load = s1_valid_q & (~out_valid_q | pop);
        s1_free  = ~s1_valid_q | out_load;
        in_pipe  = (DEPTH_LOG2 + 1)'(s1_valid_q) + (DEPTH_LOG2 + 1)'(out_valid_q);
        // Blocks still sitting in RAM are those not yet in either pipeline register.
        rd_en    = (count_q > in_pipe) & s1_free;

        wr_ptr_d    = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d    = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        s1_valid_d  = rd_en | (s1_valid_q & ~out_load);
        out_valid_d = out_load | (out_valid_q & ~pop);
        blk_data_d  = out_load ? rd_data_q : blk_data_q;
        overflow_d  = overflow_q | (push_req & ~push_ok);

        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // RAM write port; no reset so it maps onto block RAM.
    always_ff @(posedge okClk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // RAM synchronous read port; contents only matter when s1_valid_q is set.
    always_ff @(posedge okClk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    // FIFO control and output registers.
    always_ff @(posedge okClk) begin
        if (clear) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            blk_data_q  <= 64'd0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            blk_data_q  <= blk_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign blk_valid    = out_valid_q;
    assign blk_data     = blk_data_q;
    assign blk_count    = count_q;
    assign word_pending = (state_q == ST_ODD);
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_des_block_packer.sv
// tb/tb_des_block_packer.sv - self-checking bench for des_block_packer
module tb_des_block_packer;

    localparam int DL2   = 8;
    localparam int DEPTH = 256;

    logic           okClk;
    logic           reset;
    logic           flush;
    logic           in_write;
    logic [31:0]    in_data;
    logic           blk_valid;
    logic           blk_ready;
    logic [63:0]    blk_data;
    logic [DL2:0]   blk_count;
    logic           word_pending;
    logic           overflow;

    des_block_packer #(.DEPTH_LOG2(DL2)) dut (
        .okClk        (okClk),
        .reset        (reset),
        .flush        (flush),
        .in_write     (in_write),
        .in_data      (in_data),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .blk_data     (blk_data),
        .blk_count    (blk_count),
        .word_pending (word_pending),
        .overflow     (overflow)
    );

    initial begin
        okClk = 1'b0;
        forever #5 okClk = ~okClk;
    end

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    // Reference model: blocks accepted and not yet consumed, in order.
    logic [63:0] exp_q[$];
    logic        m_pend;
    logic [31:0] m_hold;
    logic        m_ovf;
    logic [63:0] last_pop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model by the rules, then compare after the edge.
    task automatic cycle(input logic wr, input logic [31:0] d, input logic rdy, input logic fl);
        int n;
        logic pop_m;
        in_write  = wr;
        in_data   = d;
        blk_ready = rdy;
        flush     = fl;
        pop_m = (blk_valid === 1'b1) && rdy;
        if (blk_valid === 1'b1) begin
            chk("valid_has_data", 64'(exp_q.size() != 0), 64'd1);
            chk("data_no_x", 64'($isunknown(blk_data)), 64'd0);
            if (exp_q.size() != 0) chk("head_block", blk_data, exp_q[0]);
        end
        if (reset || fl) begin
            exp_q.delete();
            m_pend = 1'b0;
            m_hold = 32'd0;
            m_ovf  = 1'b0;
        end else begin
            n = exp_q.size();
            if (pop_m && n != 0) last_pop = exp_q.pop_front();
            if (wr) begin
                if (!m_pend) begin
                    m_hold = d;
                    m_pend = 1'b1;
                end else begin
                    m_pend = 1'b0;
                    if (n < DEPTH || pop_m) exp_q.push_back({d, m_hold});
                    else m_ovf = 1'b1;
                end
            end
        end
        @(posedge okClk);
        #1;
        chk("blk_count", 64'(blk_count), 64'(exp_q.size()));
        chk("word_pending", 64'(word_pending), 64'(m_pend));
        chk("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic fill_words(input int n, input int base);
        for (int i = 0; i < n; i++) cycle(1'b1, 32'(base + i), 1'b0, 1'b0);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 1000) begin
            cycle(1'b0, 32'd0, 1'b1, 1'b0);
            budget++;
        end
        chk("drain_bound", 64'(exp_q.size()), 64'd0);
        cycle(1'b0, 32'd0, 1'b0, 1'b0);
        chk("drain_valid_low", 64'(blk_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] held;
        int          words;
        int          cyc;
        int          thr;

        m_pend = 1'b0; m_hold = 32'd0; m_ovf = 1'b0; last_pop = 64'd0;
        in_write = 1'b0; in_data = 32'd0; blk_ready = 1'b0; flush = 1'b0;
        reset = 1'b1;
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        cycle(1'b0, 32'd0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("rst_valid", 64'(blk_valid), 64'd0);
        chk("rst_data", blk_data, 64'd0);

        // Pairing order and two-edge fill latency.
        cycle(1'b1, 32'h1111_1111, 1'b0, 1'b0);
        cycle(1'b1, 32'h2222_2222, 1'b0, 1'b0);
        chk("lat_edge1_valid", 64'(blk_valid), 64'd0);
        idle(1);
        chk("lat_edge2_valid", 64'(blk_valid), 64'd0);
        idle(1);
        chk("lat_edge3_valid", 64'(blk_valid), 64'd1);
        chk("first_block", blk_data, 64'h2222_2222_1111_1111);
        held = blk_data;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            chk("stall_stable", blk_data, held);
        end
        drain();

        // Fill to capacity, then back-to-back drain.
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        fill_words(512, 0);
        idle(2);
        chk("full_count", 64'(blk_count), 64'd256);
        chk("full_no_ovf", 64'(overflow), 64'd0);
        for (int k = 0; k < 256; k++) begin
            chk("b2b_valid", 64'(blk_valid), 64'd1);
            chk("b2b_block", blk_data, {32'(2 * k + 1), 32'(2 * k)});
            cycle(1'b0, 32'd0, 1'b1, 1'b0);
        end
        chk("b2b_end_valid", 64'(blk_valid), 64'd0);
        chk("b2b_end_count", 64'(blk_count), 64'd0);

        // Overflow drop keeps pairing aligned.
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        fill_words(512, 0);
        fill_words(2, 512);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(blk_count), 64'd256);
        drain();
        chk("ovf_last_block", last_pop, {32'd511, 32'd510});
        cycle(1'b1, 32'd600, 1'b0, 1'b0);
        cycle(1'b1, 32'd601, 1'b0, 1'b0);
        idle(2);
        chk("realign_valid", 64'(blk_valid), 64'd1);
        chk("realign_block", blk_data, {32'd601, 32'd600});
        drain();

        // Push and pop together while full.
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        fill_words(512, 0);
        idle(2);
        cycle(1'b1, 32'd1000, 1'b0, 1'b0);
        cycle(1'b1, 32'd1001, 1'b1, 1'b0);
        chk("simul_count", 64'(blk_count), 64'd256);
        chk("simul_no_ovf", 64'(overflow), 64'd0);
        drain();
        chk("simul_last_block", last_pop, {32'd1001, 32'd1000});

        // Flush with a word in the same cycle.
        cycle(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
        cycle(1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
        cycle(1'b1, 32'hCCCC_0003, 1'b0, 1'b0);
        cycle(1'b1, 32'hDDDD_0004, 1'b0, 1'b1);
        chk("flush_valid", 64'(blk_valid), 64'd0);
        chk("flush_count", 64'(blk_count), 64'd0);
        chk("flush_pending", 64'(word_pending), 64'd0);
        cycle(1'b1, 32'hEEEE_0005, 1'b0, 1'b0);
        cycle(1'b1, 32'hFFFF_0006, 1'b0, 1'b0);
        idle(2);
        chk("post_flush_valid", 64'(blk_valid), 64'd1);
        chk("post_flush_block", blk_data, {32'hFFFF_0006, 32'hEEEE_0005});
        drain();

        // Random interleave of writes and pops.
        words = 0;
        cyc   = 0;
        thr   = 4;
        while (words < 10000 && cyc < 40000) begin
            logic wr;
            if (cyc % 1500 == 0) thr = $urandom_range(1, 8);
            wr = ($urandom_range(0, 3) != 0);
            cycle(wr, $urandom, ($urandom_range(0, 7) < thr), 1'b0);
            if (wr) words++;
            cyc++;
        end
        chk("rand_word_budget", 64'(words), 64'd10000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
